sig_gen_ctrl: RTL and testbench
===============================

Name: sig_gen_ctrl

Overview:
Front-panel controller for the sig_gen waveform datapath. It debounces three push-buttons and runs a menu state machine that edits the four sig_gen setting selectors (cnt_sig, cnt_amp, cnt_fre, cnt_phase). It drives sig_gen's confirm input, keeping confirm low until the datapath's registered settings (amp, fre_word, numOFsample, duty) have settled. It sits between the board keys and sig_gen, and its outputs connect directly to sig_gen.

Parameters:
DEB_CNT, 1000000, number of stable cycles needed to accept a key level (20 ms at 50 MHz).
SETTLE, 4, number of cycles confirm is held low between leaving edit mode and starting output. Minimum 3.

Ports:
clk  in  1  system clock; same clock as sig_gen.
rst_n  in  1  asynchronous reset, active low.
key_sel_n  in  1  raw "next field" button, active low, asynchronous to clk.
key_inc_n  in  1  raw "increment value" button, active low, asynchronous to clk.
key_ok_n  in  1  raw "run/stop" button, active low, asynchronous to clk.
cnt_sig  out  2  waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
cnt_amp  out  2  amplitude shift selector.
cnt_fre  out  2  frequency selector.
cnt_phase  out  2  phase/duty selector.
confirm  out  1  datapath enable to sig_gen.
field  out  2  field currently being edited: 0 sig, 1 amp, 2 fre, 3 phase (for LEDs).
state  out  2  current FSM state (for LEDs).

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active low.
- All outputs are registered.
- Reset values: cnt_* = 0, field = 0, confirm = 0, state = IDLE. Debouncers reset to the released level and the synchronisers reset to 1.
- Reset asserted mid-operation: confirm drops to 0 asynchronously and all settings return to 0.
- Debounce, per key:
  - 2-FF synchroniser.
  - A counter runs while the synchronised level differs from the stable level. The counter clears whenever the levels match.
  - When the counter reaches DEB_CNT-1, the stable level takes the new value.
  - A 1-cycle press pulse is generated on a stable 1->0 transition only.
  - For a clean press, the pulse is high exactly DEB_CNT+3 cycles after the first clk edge that samples the key low.
  - A low glitch shorter than DEB_CNT cycles produces no pulse. A release produces no pulse.
- Pulse priority when several pulses fire in the same cycle: ok > sel > inc. Lower-priority pulses in that cycle are discarded.
- FSM states (state encoding): IDLE=0, EDIT=1, SETTLE=2, RUN=3.
- IDLE: confirm = 0. Any pulse -> EDIT; the pulse is consumed and does not change any field or value.
- EDIT: confirm = 0.
  - sel: field <= field+1, wrapping 3->0.
  - inc: the selected cnt_* <= value+1, wrapping 3->0. The other settings are unchanged.
  - ok: -> SETTLE and load settle_cnt = SETTLE-1.
- SETTLE: confirm = 0 and settle_cnt decrements each cycle.
  - When settle_cnt == 0, go to RUN. confirm rises on the next edge, so confirm first goes high exactly SETTLE+1 cycles after the ok pulse cycle.
  - sel or inc: abort to EDIT without applying the press.
  - ok: ignored.
- RUN: confirm = 1.
  - ok: -> IDLE, confirm = 0 on the next cycle.
  - sel or inc: -> EDIT, confirm = 0 on the next cycle; the press is not applied.
- cnt_* change only in EDIT, so sig_gen never sees a setting change while confirm = 1.
- field is preserved across all transitions and reset only by rst_n.

Decomposition:
- Package sig_gen_ctrl_pkg:
  - state encodings ST_IDLE, ST_EDIT, ST_SETTLE, ST_RUN;
  - field encodings FLD_SIG, FLD_AMP, FLD_FRE, FLD_PHA;
  - waveform codes WAV_SIN, WAV_SQU, WAV_TRI, WAV_SAW.
- One sub-module, key_debounce:
  - parameter DEB_CNT;
  - ports clk, rst_n, key_n, press;
  - contains the synchroniser, counter and edge pulse.
- sig_gen_ctrl instantiates key_debounce three times and holds the FSM plus the setting registers.

Test Plan:
(All scenarios use DEB_CNT=8, SETTLE=4.)
1. Reset, then a clean key_ok_n low for 20 cycles -> the ok pulse occurs at cycle 11 after the first low sample, state goes IDLE->EDIT, cnt_* stay 0, confirm stays 0.
2. In EDIT: sel x2, inc x3, sel, inc x5 -> field=3, cnt_fre=3, cnt_phase=1, cnt_sig=0, cnt_amp=0; confirm stays 0 throughout.
3. EDIT then ok -> state passes through SETTLE and confirm first goes 1 exactly 5 cycles after the ok pulse. A second ok returns to IDLE with confirm 0 one cycle later.
4. key_inc_n bouncing (low 5, high 2, low 5, high 3 cycles) then released -> no pulse. Held low 30 cycles -> exactly one pulse, and no pulse on release.
5. In RUN, press inc -> confirm=0 the next cycle, state=EDIT, no setting changed. During SETTLE, press sel -> back to EDIT and confirm never rises.
6. Forced simultaneous ok and inc pulses in EDIT -> SETTLE is entered and no value increments. rst_n driven low mid-RUN (not at a clk edge) -> confirm=0 and all cnt_*=0 immediately.

Source files
------------

// File: rtl/sig_gen_ctrl_pkg.sv
// sig_gen_ctrl_pkg
// Shared encodings for the sig_gen front-panel controller: menu FSM states,
// the editable field selector and the waveform codes carried on cnt_sig.
package sig_gen_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FLD_SIG = 2'd0,
    FLD_AMP = 2'd1,
    FLD_FRE = 2'd2,
    FLD_PHA = 2'd3
  } field_t;

  typedef enum logic [1:0] {
    WAV_SIN = 2'd0,
    WAV_SQU = 2'd1,
    WAV_TRI = 2'd2,
    WAV_SAW = 2'd3
  } wav_t;

  // Two-bit selectors all wrap 3 -> 0 when stepped.
  function automatic logic [1:0] wrap_inc(input logic [1:0] v);
    return v + 2'd1;
  endfunction

endpackage

// File: rtl/sig_gen_ctrl_if.sv
// sig_gen_ctrl_if
// Setting/enable bundle between the front-panel controller and sig_gen.
//   cnt_sig   : waveform select (sine, square, triangle, sawtooth)
//   cnt_amp   : amplitude shift selector
//   cnt_fre   : frequency selector
//   cnt_phase : phase/duty selector
//   confirm   : datapath enable
// master = controller side (drives), slave = sig_gen side (receives).
interface sig_gen_ctrl_if;
  logic [1:0] cnt_sig;
  logic [1:0] cnt_amp;
  logic [1:0] cnt_fre;
  logic [1:0] cnt_phase;
  logic       confirm;

  modport master (output cnt_sig, cnt_amp, cnt_fre, cnt_phase, confirm);
  modport slave  (input  cnt_sig, cnt_amp, cnt_fre, cnt_phase, confirm);
endinterface

// File: rtl/sig_gen_ctrl_key_debounce.sv
// key_debounce
// Debounces one raw active-low push-button and emits a single-cycle press
// pulse on an accepted 1->0 transition of the stable level.
//   clk   : system clock
//   rst_n : asynchronous reset, active low
//   key_n : raw button level, asynchronous to clk
//   press : one-cycle pulse per accepted press (releases give nothing)
module key_debounce #(
  parameter int DEB_CNT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CNT + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_q;
  logic          fall;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser; resets to the released level so no press is seen
  // coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // The counter only advances while the synchronised level disagrees with
  // the accepted level; any agreement restarts the qualification window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (sync2 != stable) begin
      if (cnt == CW'(DEB_CNT - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // Falling-edge detect is pipelined one extra stage so the pulse lands
  // DEB_CNT+3 cycles after the first low sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b1;
      fall     <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_q <= stable;
      fall     <= stable_q & ~stable;
      press    <= fall;
    end
  end

endmodule

// File: rtl/sig_gen_ctrl.sv
// sig_gen_ctrl
// Front-panel controller for the sig_gen datapath: three debounced keys
// drive a menu FSM that edits the four setting selectors and gates confirm
// so the datapath only runs once its registered settings have settled.
//   clk, rst_n       : system clock, asynchronous active-low reset
//   key_sel_n        : raw "next field" button (active low)
//   key_inc_n        : raw "increment value" button (active low)
//   key_ok_n         : raw "run/stop" button (active low)
//   sg               : settings + confirm towards sig_gen (master side)
//   field            : field being edited, for LEDs
//   state            : FSM state, for LEDs
module sig_gen_ctrl
  import sig_gen_ctrl_pkg::*;
#(
  parameter int DEB_CNT = 1000000,
  parameter int SETTLE  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_sel_n,
  input  logic                 key_inc_n,
  input  logic                 key_ok_n,
  sig_gen_ctrl_if.master       sg,
  output logic [1:0]           field,
  output logic [1:0]           state
);

  localparam int SW = $clog2(SETTLE + 1);

  logic sel_p, inc_p, ok_p;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_sel (.clk(clk), .rst_n(rst_n), .key_n(key_sel_n), .press(sel_p));
  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_inc (.clk(clk), .rst_n(rst_n), .key_n(key_inc_n), .press(inc_p));
  key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_ok  (.clk(clk), .rst_n(rst_n), .key_n(key_ok_n),  .press(ok_p));

  state_t          st_q, st_d;
  field_t          fld_q, fld_d;
  logic [1:0]      sig_q, sig_d, amp_q, amp_d, fre_q, fre_d, pha_q, pha_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            conf_q, conf_d;

  // Next-state and setting updates. ok outranks sel, which outranks inc;
  // lower-priority pulses in the same cycle are simply dropped.
  always_comb begin
    st_d     = st_q;
    fld_d    = fld_q;
    sig_d    = sig_q;
    amp_d    = amp_q;
    fre_d    = fre_q;
    pha_d    = pha_q;
    settle_d = settle_q;
    case (st_q)
      ST_IDLE: begin
        if (ok_p || sel_p || inc_p) st_d = ST_EDIT;
      end
      ST_EDIT: begin
        if (ok_p) begin
          st_d     = ST_SETTLE;
          settle_d = SW'(SETTLE - 1);
        end else if (sel_p) begin
          fld_d = field_t'(wrap_inc(fld_q));
        end else if (inc_p) begin
          case (fld_q)
            FLD_SIG: sig_d = wrap_inc(sig_q);
            FLD_AMP: amp_d = wrap_inc(amp_q);
            FLD_FRE: fre_d = wrap_inc(fre_q);
            default: pha_d = wrap_inc(pha_q);
          endcase
        end
      end
      ST_SETTLE: begin
        // A concurrent ok masks sel/inc here, so only a lone sel/inc aborts.
        if (!ok_p && (sel_p || inc_p)) begin
          st_d = ST_EDIT;
        end else if (settle_q == '0) begin
          st_d = ST_RUN;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      ST_RUN: begin
        if (ok_p)                st_d = ST_IDLE;
        else if (sel_p || inc_p) st_d = ST_EDIT;
      end
      default: st_d = ST_IDLE;
    endcase
    // confirm is registered from the next state so it rises on the same edge
    // that enters RUN and falls on the edge that leaves it.
    conf_d = (st_d == ST_RUN);
  end

  // State, settings and confirm registers; reset drops confirm immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      fld_q    <= FLD_SIG;
      sig_q    <= WAV_SIN;
      amp_q    <= 2'd0;
      fre_q    <= 2'd0;
      pha_q    <= 2'd0;
      settle_q <= '0;
      conf_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      fld_q    <= fld_d;
      sig_q    <= sig_d;
      amp_q    <= amp_d;
      fre_q    <= fre_d;
      pha_q    <= pha_d;
      settle_q <= settle_d;
      conf_q   <= conf_d;
    end
  end

  assign sg.cnt_sig   = sig_q;
  assign sg.cnt_amp   = amp_q;
  assign sg.cnt_fre   = fre_q;
  assign sg.cnt_phase = pha_q;
  assign sg.confirm   = conf_q;
  assign field        = fld_q;
  assign state        = st_q;

endmodule

// File: tb/tb_sig_gen_ctrl.sv
// tb_sig_gen_ctrl
// Self-checking bench for sig_gen_ctrl with DEB_CNT=8, SETTLE=4: reset state,
// timed press/settle sequences, a vector table for the edit menu, bounce and
// priority corner cases, an asynchronous mid-run reset and a randomized
// press sequence checked against an abstract menu model.
module tb_sig_gen_ctrl;

  localparam int DEB = 8;
  localparam int SET = 4;

  localparam int KOK  = 0;
  localparam int KSEL = 1;
  localparam int KINC = 2;

  localparam int S_IDLE   = 0;
  localparam int S_EDIT   = 1;
  localparam int S_SETTLE = 2;
  localparam int S_RUN    = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_sel_n, key_inc_n, key_ok_n;
  logic [1:0] field, state;

  sig_gen_ctrl_if sg_if ();

  sig_gen_ctrl #(.DEB_CNT(DEB), .SETTLE(SET)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_sel_n (key_sel_n),
    .key_inc_n (key_inc_n),
    .key_ok_n  (key_ok_n),
    .sg        (sg_if),
    .field     (field),
    .state     (state)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int stHist[64];
  int cfHist[64];

  typedef struct {
    int key;
    int expState;
    int expField;
    int expSig;
    int expAmp;
    int expFre;
    int expPha;
    int expConf;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic checkAll(input string tag, input int st, input int fld, input int sig,
                          input int amp, input int fre, input int pha, input int cf);
    checkOutput({tag, ".state"},   int'(state),           st);
    checkOutput({tag, ".field"},   int'(field),           fld);
    checkOutput({tag, ".cnt_sig"}, int'(sg_if.cnt_sig),   sig);
    checkOutput({tag, ".cnt_amp"}, int'(sg_if.cnt_amp),   amp);
    checkOutput({tag, ".cnt_fre"}, int'(sg_if.cnt_fre),   fre);
    checkOutput({tag, ".cnt_pha"}, int'(sg_if.cnt_phase), pha);
    checkOutput({tag, ".confirm"}, int'(sg_if.confirm),   cf);
  endtask

  task automatic setKey(input int k, input logic v);
    case (k)
      KOK:     key_ok_n  = v;
      KSEL:    key_sel_n = v;
      default: key_inc_n = v;
    endcase
  endtask

  // Hold one key low for lowCyc samples, then released for highCyc cycles.
  task automatic applyStimulus(input int k, input int lowCyc, input int highCyc);
    @(negedge clk);
    setKey(k, 1'b0);
    repeat (lowCyc) @(negedge clk);
    setKey(k, 1'b1);
    repeat (highCyc) @(negedge clk);
  endtask

  // Edge-indexed recording: edge 0 is the first edge sampling k1 low; k2
  // (if >= 0) first samples low at edge off2. Both held lowCyc samples.
  task automatic runTimed(input int k1, input int k2, input int off2,
                          input int lowCyc, input int nEdges);
    @(negedge clk);
    setKey(k1, 1'b0);
    if (k2 >= 0 && off2 == 0) setKey(k2, 1'b0);
    for (int e = 0; e < nEdges; e++) begin
      @(posedge clk);
      #1;
      stHist[e] = int'(state);
      cfHist[e] = int'(sg_if.confirm);
      if (e + 1 == lowCyc) setKey(k1, 1'b1);
      if (k2 >= 0 && off2 > 0 && e + 1 == off2) setKey(k2, 1'b0);
      if (k2 >= 0 && e + 1 == off2 + lowCyc) setKey(k2, 1'b1);
    end
  endtask

  function automatic int firstHigh(input int nEdges);
    for (int e = 0; e < nEdges; e++) if (cfHist[e] != 0) return e;
    return -1;
  endfunction

  // Abstract menu model: waits are long enough that SETTLE always completes,
  // so an ok in EDIT lands in RUN.
  int mState, mField;
  int mCnt[4];

  task automatic modelPress(input int k);
    case (mState)
      S_IDLE: mState = S_EDIT;
      S_EDIT: begin
        if (k == KOK)       mState = S_RUN;
        else if (k == KSEL) mField = (mField + 1) % 4;
        else                mCnt[mField] = (mCnt[mField] + 1) % 4;
      end
      default: mState = (k == KOK) ? S_IDLE : S_EDIT;
    endcase
  endtask

  initial begin
    rst_n = 1'b0;
    key_sel_n = 1'b1;
    key_inc_n = 1'b1;
    key_ok_n  = 1'b1;

    vecs[0]  = '{KSEL, S_EDIT, 1, 0, 0, 0, 0, 0};
    vecs[1]  = '{KSEL, S_EDIT, 2, 0, 0, 0, 0, 0};
    vecs[2]  = '{KINC, S_EDIT, 2, 0, 0, 1, 0, 0};
    vecs[3]  = '{KINC, S_EDIT, 2, 0, 0, 2, 0, 0};
    vecs[4]  = '{KINC, S_EDIT, 2, 0, 0, 3, 0, 0};
    vecs[5]  = '{KSEL, S_EDIT, 3, 0, 0, 3, 0, 0};
    vecs[6]  = '{KINC, S_EDIT, 3, 0, 0, 3, 1, 0};
    vecs[7]  = '{KINC, S_EDIT, 3, 0, 0, 3, 2, 0};
    vecs[8]  = '{KINC, S_EDIT, 3, 0, 0, 3, 3, 0};
    vecs[9]  = '{KINC, S_EDIT, 3, 0, 0, 3, 0, 0};
    vecs[10] = '{KINC, S_EDIT, 3, 0, 0, 3, 1, 0};
    vecs[11] = '{KOK,  S_RUN,  3, 0, 0, 3, 1, 1};
    vecs[12] = '{KOK,  S_IDLE, 3, 0, 0, 3, 1, 0};
    vecs[13] = '{KSEL, S_EDIT, 3, 0, 0, 3, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    checkAll("reset", S_IDLE, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean ok press: pulse in cycle 11, consumed by IDLE -> EDIT at edge 12
    runTimed(KOK, -1, 0, 20, 40);
    checkOutput("t1.state_e11", stHist[11], S_IDLE);
    checkOutput("t1.state_e12", stHist[12], S_EDIT);
    checkOutput("t1.conf_any",  firstHigh(40), -1);
    checkAll("t1.end", S_EDIT, 0, 0, 0, 0, 0, 0);

    // Edit-menu vector table
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].key, 15, 25);
      checkAll($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expField, vecs[i].expSig,
               vecs[i].expAmp, vecs[i].expFre, vecs[i].expPha, vecs[i].expConf);
    end

    // ok in EDIT: SETTLE, confirm first high SETTLE+1 cycles after pulse
    runTimed(KOK, -1, 0, 20, 40);
    checkOutput("t3.state_e12", stHist[12], S_SETTLE);
    checkOutput("t3.state_e15", stHist[15], S_SETTLE);
    checkOutput("t3.state_e16", stHist[16], S_RUN);
    checkOutput("t3.conf_first", firstHigh(40), 11 + SET + 1);
    runTimed(KOK, -1, 0, 20, 40);
    checkOutput("t3.stop_conf_e11", cfHist[11], 1);
    checkOutput("t3.stop_conf_e12", cfHist[12], 0);
    checkOutput("t3.stop_state_e12", stHist[12], S_IDLE);

    // Bouncing inc key produces nothing; a long hold gives exactly one step
    applyStimulus(KSEL, 15, 25);
    @(negedge clk);
    key_inc_n = 1'b0; repeat (5) @(negedge clk);
    key_inc_n = 1'b1; repeat (2) @(negedge clk);
    key_inc_n = 1'b0; repeat (5) @(negedge clk);
    key_inc_n = 1'b1; repeat (30) @(negedge clk);
    checkAll("t4.bounce", S_EDIT, 3, 0, 0, 3, 1, 0);
    applyStimulus(KINC, 30, 30);
    checkAll("t4.hold", S_EDIT, 3, 0, 0, 3, 2, 0);

    // inc during RUN: drop to EDIT, press not applied
    applyStimulus(KOK, 15, 25);
    checkAll("t5.run", S_RUN, 3, 0, 0, 3, 2, 1);
    runTimed(KINC, -1, 0, 20, 40);
    checkOutput("t5.conf_e11", cfHist[11], 1);
    checkOutput("t5.conf_e12", cfHist[12], 0);
    checkOutput("t5.state_e12", stHist[12], S_EDIT);
    checkAll("t5.after_inc", S_EDIT, 3, 0, 0, 3, 2, 0);

    // sel during SETTLE aborts to EDIT and confirm never rises
    runTimed(KOK, KSEL, 2, 20, 40);
    checkOutput("t5.settle_e12", stHist[12], S_SETTLE);
    checkOutput("t5.abort_e14", stHist[14], S_EDIT);
    checkOutput("t5.abort_conf", firstHigh(40), -1);
    checkAll("t5.after_abort", S_EDIT, 3, 0, 0, 3, 2, 0);

    // Simultaneous ok+inc in EDIT: ok wins, no increment
    runTimed(KOK, KINC, 0, 20, 40);
    checkOutput("t6.state_e12", stHist[12], S_SETTLE);
    checkOutput("t6.conf_first", firstHigh(40), 11 + SET + 1);
    checkAll("t6.run", S_RUN, 3, 0, 0, 3, 2, 1);

    // Asynchronous reset mid-RUN, away from a clock edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkAll("t6.async_rst", S_IDLE, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized presses and glitches against the menu model
    mState = S_IDLE;
    mField = 0;
    for (int i = 0; i < 4; i++) mCnt[i] = 0;
    for (int n = 0; n < 40; n++) begin
      int k;
      k = int'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) begin
        applyStimulus(k, int'($urandom_range(1, DEB - 2)), int'($urandom_range(20, 30)));
      end else begin
        applyStimulus(k, int'($urandom_range(DEB + 2, 25)), int'($urandom_range(20, 30)));
        modelPress(k);
      end
      checkAll($sformatf("rnd%0d", n), mState, mField, mCnt[0], mCnt[1], mCnt[2], mCnt[3],
               (mState == S_RUN) ? 1 : 0);
    end

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
